set_job_scheduler: RTL and testbench
====================================

# set_job_scheduler

Two-requester front end for the SET point-counting engine. It arbitrates round-robin between two request ports, latches one job (central, radius, mode), and issues it to the engine with a single-cycle enable. It captures the engine's final candidate count on the engine's valid pulse and returns it over a held response handshake. It also screens out illegal mode 3 jobs and recovers from a hung engine with a watchdog.

## Interface
- TIMEOUT_CYC, 80, max cycles in RUN waiting for eng_valid before an error response (8-bit counter; legal 67..255)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  port 0 job request
- req0_ready  out  1  port 0 accept; the job transfers when valid&&ready
- req0_central  in  24  {ax,ay,bx,by,8'h0} nibbles
- req0_radius  in  12  {ar,br,4'h0}
- req0_mode  in  2  0=A, 1=A∩B, 2=A xor B, 3=illegal
- req1_valid / req1_ready / req1_central / req1_radius / req1_mode: same as port 0, for port 1
- eng_en  out  1  engine start pulse
- eng_central  out  24  latched job central
- eng_radius  out  12  latched job radius
- eng_mode  out  2  latched job mode
- eng_busy  in  1  engine busy
- eng_valid  in  1  engine result pulse; eng_candidate is final in this cycle
- eng_candidate  in  8  engine count
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer accept
- rsp_id  out  1  port that issued the job
- rsp_candidate  out  8  result; 0 on error
- rsp_err  out  1  1 = illegal mode or timeout

## Operation
- States: IDLE, ISSUE, RUN, RESP.
- IDLE: when eng_busy==0, pick a winner among the valid ports.
  - One valid port: that port wins.
  - Both valid: the port not granted last wins. After reset, port 0 wins.
  - reqN_ready=1 only for the winner. It is combinational from state, eng_busy and the req valids.
- On handshake: latch payload and id, and update the last-grant pointer.
  - mode!=3: go to ISSUE.
  - mode==3: go to RESP with rsp_err=1, rsp_candidate=0. eng_en is never asserted.
- ISSUE: eng_en=1 for exactly one cycle; eng_* payload stable. Go to RUN and clear the watchdog.
- RUN: the watchdog increments every cycle.
  - eng_valid=1: capture eng_candidate, rsp_err=0, go to RESP.
  - Counter reaches TIMEOUT_CYC-1 with no eng_valid: rsp_err=1, rsp_candidate=0, go to RESP.
  - eng_valid takes priority when both occur in the same cycle.
- RESP: rsp_valid=1; rsp_id, rsp_candidate and rsp_err are held stable. On rsp_ready, go to IDLE.
- eng_valid outside RUN is ignored.
- After a timeout, no new job is accepted while eng_busy stays 1.
- eng_central, eng_radius and eng_mode hold the last latched job until the next handshake.

## Timing
- Reset values: all ready=0, eng_en=0, eng_* payload=0, rsp_valid=0, rsp_id=0, rsp_candidate=0, rsp_err=0. State=IDLE, last-grant pointer=1 (so port 0 wins first), watchdog=0.
- Reset mid-job drops the job silently; no response is produced.
- Normal job, request accepted at cycle T:
  - T+1: eng_en=1.
  - T+2: eng_busy=1.
  - T+66: eng_valid=1.
  - T+67: rsp_valid=1 and eng_busy=0.
- Back-to-back: if rsp_ready=1 at T+67, IDLE at T+68 and the next handshake is possible at T+68.
- Mode-3 job accepted at T: rsp_valid=1 at T+1.
- Timeout: rsp_valid at ISSUE+1+TIMEOUT_CYC.
- At most one job is outstanding; no request is accepted from ISSUE through the RESP handshake.

## Test plan
- Single job: port0 central=24'h440000, radius=12'h300, mode=0 -> one eng_en pulse at T+1; rsp_valid at T+67 with rsp_id=0, rsp_candidate=29, rsp_err=0.
- Arbitration: both ports valid at the first cycle after reset, both mode 0 with the payload above -> port0 is served first, then port1; rsp_id sequence 0,1; each port sees exactly one ready pulse.
- Illegal mode: req1 mode=3 -> rsp_valid next cycle with rsp_id=1, rsp_err=1, rsp_candidate=0; eng_en stays 0 throughout.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> response fields stay stable and both req ready signals stay 0; the handshake completes on the first rsp_ready=1.
- Timeout: stub engine holds eng_busy=1 and never pulses valid, TIMEOUT_CYC=80 -> rsp_err=1, rsp_candidate=0 at ISSUE+81; no new job is accepted while the stub holds busy.
- Reset mid-RUN: assert rst at T+30 -> all outputs return to reset values immediately; no response is produced; after release, port 0 has priority again.

Source files
------------

// File: rtl/set_job_scheduler_if.sv
// Job request, engine and response signal bundle for the SET job scheduler.
// slave = scheduler side, master = requesters/engine/consumer side.
interface set_job_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [23:0] req0_central;
  logic [11:0] req0_radius;
  logic [1:0]  req0_mode;
  logic        req1_valid;
  logic        req1_ready;
  logic [23:0] req1_central;
  logic [11:0] req1_radius;
  logic [1:0]  req1_mode;
  logic        eng_en;
  logic [23:0] eng_central;
  logic [11:0] eng_radius;
  logic [1:0]  eng_mode;
  logic        eng_busy;
  logic        eng_valid;
  logic [7:0]  eng_candidate;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_candidate;
  logic        rsp_err;

  modport slave (
    input  req0_valid, req0_central, req0_radius, req0_mode,
    input  req1_valid, req1_central, req1_radius, req1_mode,
    input  eng_busy, eng_valid, eng_candidate, rsp_ready,
    output req0_ready, req1_ready,
    output eng_en, eng_central, eng_radius, eng_mode,
    output rsp_valid, rsp_id, rsp_candidate, rsp_err
  );

  modport master (
    output req0_valid, req0_central, req0_radius, req0_mode,
    output req1_valid, req1_central, req1_radius, req1_mode,
    output eng_busy, eng_valid, eng_candidate, rsp_ready,
    input  req0_ready, req1_ready,
    input  eng_en, eng_central, eng_radius, eng_mode,
    input  rsp_valid, rsp_id, rsp_candidate, rsp_err
  );
endinterface

// File: rtl/set_job_scheduler.sv
// Two-port round-robin front end for the SET point-counting engine:
// accepts one job at a time, issues it with a one-cycle enable, waits for the
// engine result (or a watchdog timeout) and returns it over a held response.
module set_job_scheduler #(
  parameter int unsigned TIMEOUT_CYC = 80
) (
  input logic                  clk,
  input logic                  rst,
  set_job_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESP} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  state_t      state_q, state_d;
  logic        last_q, last_d;        // port granted most recently
  logic [7:0]  wd_q, wd_d;            // RUN-state watchdog
  logic [23:0] central_q, central_d;
  logic [11:0] radius_q, radius_d;
  logic [1:0]  mode_q, mode_d;
  logic        id_q, id_d;
  logic [7:0]  cand_q, cand_d;
  logic        err_q, err_d;

  logic        grant_any;
  logic        winner;
  logic [23:0] win_central;
  logic [11:0] win_radius;
  logic [1:0]  win_mode;

  // Arbitration: the port not granted last wins a tie; ready only for the winner.
  // Readies are held low while reset is asserted so they match the reset state.
  always_comb begin
    winner      = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
    grant_any   = !rst && (state_q == IDLE) && !bus.eng_busy &&
                  (bus.req0_valid || bus.req1_valid);
    win_central = winner ? bus.req1_central : bus.req0_central;
    win_radius  = winner ? bus.req1_radius  : bus.req0_radius;
    win_mode    = winner ? bus.req1_mode    : bus.req0_mode;
  end

  assign bus.req0_ready    = grant_any && !winner;
  assign bus.req1_ready    = grant_any &&  winner;
  assign bus.eng_en        = (state_q == ISSUE);
  assign bus.eng_central   = central_q;
  assign bus.eng_radius    = radius_q;
  assign bus.eng_mode      = mode_q;
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.rsp_id        = id_q;
  assign bus.rsp_candidate = cand_q;
  assign bus.rsp_err       = err_q;

  // Next-state logic: job latch, engine issue, watchdog and response capture.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wd_d      = wd_q;
    central_d = central_q;
    radius_d  = radius_q;
    mode_d    = mode_q;
    id_d      = id_q;
    cand_d    = cand_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          central_d = win_central;
          radius_d  = win_radius;
          mode_d    = win_mode;
          id_d      = winner;
          last_d    = winner;
          if (win_mode == MODE_ILLEGAL) begin
            // Illegal jobs never reach the engine; answer with an error at once.
            err_d   = 1'b1;
            cand_d  = 8'd0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        wd_d    = 8'd0;
        state_d = RUN;
      end
      RUN: begin
        // A result pulse wins over a simultaneous watchdog expiry.
        if (bus.eng_valid) begin
          cand_d  = bus.eng_candidate;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          cand_d  = 8'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any job in flight and re-arms port 0 priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      wd_q      <= 8'd0;
      central_q <= 24'd0;
      radius_q  <= 12'd0;
      mode_q    <= 2'd0;
      id_q      <= 1'b0;
      cand_q    <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      mode_q    <= mode_d;
      id_q      <= id_d;
      cand_q    <= cand_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_set_job_scheduler.sv
// Bench for set_job_scheduler: engine stub, request driver and a response
// scoreboard filled at each request handshake and drained on each response.
module tb_set_job_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  set_job_scheduler_if bus();

  set_job_scheduler #(.TIMEOUT_CYC(80)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- engine stub ----------------
  logic       stub_hang;
  logic       stub_stray;
  logic [7:0] stub_cand;
  logic       en_seen;
  logic       running;
  logic       hung;
  int         ecnt;

  always @(negedge clk) en_seen <= bus.eng_en;

  // Busy from enable+1, result pulse 64 cycles later, busy drops the cycle after.
  always @(posedge clk) begin
    if (rst) begin
      bus.eng_busy      <= 1'b0;
      bus.eng_valid     <= 1'b0;
      bus.eng_candidate <= 8'hA5;
      running           <= 1'b0;
      hung              <= 1'b0;
      ecnt              <= 0;
    end else begin
      bus.eng_valid     <= stub_stray;
      bus.eng_candidate <= 8'hA5;
      if (en_seen && stub_hang) begin
        hung         <= 1'b1;
        bus.eng_busy <= 1'b1;
      end else if (en_seen) begin
        running      <= 1'b1;
        ecnt         <= 0;
        bus.eng_busy <= 1'b1;
      end else if (running) begin
        ecnt <= ecnt + 1;
        if (ecnt == 63) begin
          bus.eng_valid     <= 1'b1;
          bus.eng_candidate <= stub_cand;
        end
        if (ecnt == 64) begin
          bus.eng_busy <= 1'b0;
          running      <= 1'b0;
        end
      end else if (hung && !stub_hang) begin
        hung         <= 1'b0;
        bus.eng_busy <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          id;
    int          cand;
    int          err;
    int          rsp_at;
    int          en_at;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb[$];
  int   order[$];
  int   hs_at[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   rdy_cnt0 = 0;
  int   rdy_cnt1 = 0;
  int   en_cnt = 0;
  logic last_m = 1'b1;
  logic rsp_prev = 1'b0;
  logic drop0 = 1'b0;
  logic drop1 = 1'b0;
  logic       held_id;
  logic [7:0] held_cand;
  logic       held_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One negedge observation of every DUT output.
  task automatic sample();
    exp_t        e;
    logic        v0, v1, vp, rp;
    logic [23:0] c;
    logic [11:0] r;
    logic [1:0]  m;
    int          w;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    if (bus.req0_ready) rdy_cnt0++;
    if (bus.req1_ready) rdy_cnt1++;
    for (int p = 0; p < 2; p++) begin
      vp = (p == 0) ? bus.req0_valid   : bus.req1_valid;
      rp = (p == 0) ? bus.req0_ready   : bus.req1_ready;
      c  = (p == 0) ? bus.req0_central : bus.req1_central;
      r  = (p == 0) ? bus.req0_radius  : bus.req1_radius;
      m  = (p == 0) ? bus.req0_mode    : bus.req1_mode;
      if (vp && rp) begin
        w = (v0 && v1) ? (last_m ? 0 : 1) : (v1 ? 1 : 0);
        chk("grant", p, w);
        last_m    = (p == 1);
        e.id      = p;
        e.central = c;
        e.radius  = r;
        e.mode    = m;
        e.en_at   = cyc + 1;
        if (m == 2'd3) begin
          e.cand = 0;  e.err = 1;  e.rsp_at = cyc + 1;
        end else if (stub_hang) begin
          e.cand = 0;  e.err = 1;  e.rsp_at = cyc + 82;
        end else begin
          e.cand = stub_cand;  e.err = 0;  e.rsp_at = cyc + 67;
        end
        sb.push_back(e);
        order.push_back(p);
        hs_at.push_back(cyc);
        if (p == 0) drop0 = 1'b1; else drop1 = 1'b1;
      end
    end
    if (bus.eng_en) begin
      en_cnt++;
      if (sb.size() == 0) chk("eng_en_spurious", 1, 0);
      else begin
        chk("eng_en_cyc", cyc, sb[$].en_at);
        chk("eng_en_mode3", (sb[$].mode == 2'd3), 0);
        chk("eng_central", bus.eng_central, sb[$].central);
        chk("eng_radius", bus.eng_radius, sb[$].radius);
        chk("eng_mode", bus.eng_mode, sb[$].mode);
      end
    end
    if (bus.rsp_valid) begin
      if (!rsp_prev) begin
        if (sb.size() == 0) chk("rsp_spurious", 1, 0);
        else chk("rsp_cyc", cyc, sb[0].rsp_at);
        held_id   = bus.rsp_id;
        held_cand = bus.rsp_candidate;
        held_err  = bus.rsp_err;
      end else begin
        chk("hold_id", bus.rsp_id, held_id);
        chk("hold_cand", bus.rsp_candidate, held_cand);
        chk("hold_err", bus.rsp_err, held_err);
      end
      chk("ready_in_resp", {bus.req0_ready, bus.req1_ready}, 0);
      if (bus.rsp_ready) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          $display("rsp id=%0d cand=%0d err=%0d cycle=%0d", bus.rsp_id,
                   bus.rsp_candidate, bus.rsp_err, cyc);
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_cand", bus.rsp_candidate, e.cand);
          chk("rsp_err", bus.rsp_err, e.err);
        end
        rsp_prev = 1'b0;
      end else begin
        rsp_prev = 1'b1;
      end
    end else begin
      rsp_prev = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (drop0) begin bus.req0_valid = 1'b0; drop0 = 1'b0; end
    if (drop1) begin bus.req1_valid = 1'b0; drop1 = 1'b0; end
  endtask

  task automatic drain(input int maxc, input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.req0_valid || bus.req1_valid) && n < maxc) begin
      tick();
      n++;
    end
    if (n >= maxc) chk(tag, 0, 1);
    repeat (2) tick();
  endtask

  task automatic set_req(input int p, input logic [23:0] c, input logic [11:0] r,
                         input logic [1:0] m);
    if (p == 0) begin
      bus.req0_central = c; bus.req0_radius = r; bus.req0_mode = m; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_central = c; bus.req1_radius = r; bus.req1_mode = m; bus.req1_valid = 1'b1;
    end
  endtask

  task automatic check_reset();
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_eng_en", bus.eng_en, 0);
    chk("rst_eng_central", bus.eng_central, 0);
    chk("rst_eng_radius", bus.eng_radius, 0);
    chk("rst_eng_mode", bus.eng_mode, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_cand", bus.rsp_candidate, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int base, en0, n, t0;
    rst = 1'b1;
    bus.req0_valid = 0; bus.req0_central = 0; bus.req0_radius = 0; bus.req0_mode = 0;
    bus.req1_valid = 0; bus.req1_central = 0; bus.req1_radius = 0; bus.req1_mode = 0;
    bus.rsp_ready = 1'b1;
    stub_hang = 0; stub_stray = 0; stub_cand = 8'd29;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;

    // Arbitration from reset: both valid, port 0 then port 1, back-to-back.
    set_req(0, 24'h440000, 12'h300, 2'd0);
    set_req(1, 24'h440000, 12'h300, 2'd0);
    drain(300, "arb_bound");
    chk("arb_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("arb_first", order[0], 0);
      chk("arb_second", order[1], 1);
      chk("b2b_gap", hs_at[1] - hs_at[0], 68);
    end
    chk("arb_rdy0", rdy_cnt0, 1);
    chk("arb_rdy1", rdy_cnt1, 1);
    chk("arb_en", en_cnt, 2);

    // Stray result pulse while idle must not create a response.
    stub_stray = 1'b1;
    tick();
    stub_stray = 1'b0;
    repeat (4) tick();

    // Single port-0 job, then a tie with port 0 last granted -> port 1 first.
    stub_cand = 8'd7;
    set_req(0, 24'h440000, 12'h300, 2'd1);
    drain(150, "single_bound");
    order.delete(); hs_at.delete();
    set_req(0, 24'h9abc00, 12'h560, 2'd1);
    set_req(1, 24'h123400, 12'h780, 2'd2);
    drain(300, "rr_bound");
    if (order.size() == 2) begin
      chk("rr_first", order[0], 1);
      chk("rr_second", order[1], 0);
    end else chk("rr_count", order.size(), 2);

    // Illegal mode on port 1: immediate error response, no engine start.
    en0 = en_cnt;
    set_req(1, 24'h111100, 12'h120, 2'd3);
    drain(20, "mode3_bound");
    chk("mode3_no_en", en_cnt, en0);

    // Backpressure: response held 10 cycles, port 1 waiting meanwhile.
    stub_cand = 8'd29;
    bus.rsp_ready = 1'b0;
    set_req(0, 24'h440000, 12'h300, 2'd0);
    n = 0;
    while (!bus.rsp_valid && n < 200) begin tick(); n++; end
    if (n >= 200) chk("bp_rsp_bound", 0, 1);
    set_req(1, 24'h220000, 12'h100, 2'd0);
    repeat (10) tick();
    base = sb.size();
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_first_ready", sb.size(), base - 1);
    drain(200, "bp_bound");

    // Timeout: engine hangs busy; no new job while busy stays high.
    stub_hang = 1'b1;
    set_req(0, 24'h440000, 12'h300, 2'd0);
    drain(150, "to_bound");
    base = rdy_cnt1;
    set_req(1, 24'h330000, 12'h200, 2'd0);
    repeat (20) tick();
    chk("to_hold_rdy1", rdy_cnt1 - base, 0);
    chk("to_hold_sb", sb.size(), 0);
    stub_hang = 1'b0;
    drain(150, "to_release_bound");

    // Reset mid-RUN: job dropped, outputs at reset values, port 0 first again.
    order.delete(); hs_at.delete();
    set_req(0, 24'h440000, 12'h300, 2'd0);
    n = 0;
    while (hs_at.size() == 0 && n < 20) begin tick(); n++; end
    t0 = (hs_at.size() != 0) ? hs_at[0] : cyc;
    if (hs_at.size() == 0) chk("mid_hs_bound", 0, 1);
    while (cyc < t0 + 30) tick();
    rst = 1'b1;
    #1;
    check_reset();
    sb.delete();
    rsp_prev = 1'b0; last_m = 1'b1; drop0 = 1'b0; drop1 = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (70) tick();
    order.delete(); hs_at.delete();
    set_req(1, 24'h440000, 12'h300, 2'd0);
    set_req(0, 24'h440000, 12'h300, 2'd0);
    drain(300, "post_rst_bound");
    if (order.size() == 2) chk("post_rst_first", order[0], 0);
    else chk("post_rst_count", order.size(), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
